noc_rr_arbiter: RTL and testbench

Parametrised output-port arbiter for the NoC router. It selects one of `NUM_PORTS` input channels with a rotating-priority search. It drives the crossbar select and runs the RTS/DCTS handshake toward the downstream router. Unlike the fixed 5-port arbiter, it supports:
- a configurable port count;
- a fairness mode, in which the current owner yields to other requesters;
- a packet-lock mode, in which ownership is held until the tail flit transfers.

---
 rtl/noc_pkg.sv | 21 ++
 rtl/rr_pick.sv | 45 ++++
 rtl/noc_rr_arbiter.sv | 94 +++++++++
 tb/tb_noc_rr_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: arbiter state encoding, index width helper
// and the legacy 5-port direction numbering.
package noc_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } arb_state_t;

    localparam int PORT_L = 0;
    localparam int PORT_N = 1;
    localparam int PORT_E = 2;
    localparam int PORT_W = 3;
    localparam int PORT_S = 4;

    // At least one bit, so a 2-port index still has a usable width.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: the first requester at or after 'start', modulo
// NUM_PORTS, found with a double-width masked priority encoder.
module rr_pick
    import noc_pkg::*;
#(
    parameter int NUM_PORTS = 5,
    parameter int IDX_W     = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     start,
    output logic [NUM_PORTS-1:0] onehot,
    output logic [IDX_W-1:0]     idx,
    output logic                 any
);

    localparam int HIT_W = IDX_W + 1;

    logic [2*NUM_PORTS-1:0] doubled;
    logic [2*NUM_PORTS-1:0] mask;
    logic [2*NUM_PORTS-1:0] masked;
    logic [HIT_W-1:0]       hit;

    // Masking bits below 'start' leaves the upper copy to supply the wrap-around.
    always_comb begin
        doubled = {req, req};
        mask    = '0;
        for (int i = 0; i < 2*NUM_PORTS; i++) begin
            mask[i] = (i >= int'(start));
        end
        masked = doubled & mask;
        hit    = '0;
        for (int i = 2*NUM_PORTS-1; i >= 0; i--) begin
            if (masked[i]) begin
                hit = HIT_W'(i);
            end
        end
        any = |req;
        idx = (hit >= HIT_W'(NUM_PORTS)) ? IDX_W'(hit - HIT_W'(NUM_PORTS)) : IDX_W'(hit);
        onehot = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            onehot[j] = any && (idx == IDX_W'(j));
        end
    end

endmodule

// File: rtl/noc_rr_arbiter.sv
// Output-port arbiter: rotating-priority owner selection, crossbar select and
// the registered RTS/DCTS handshake toward the downstream router.
module noc_rr_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_PORTS   = 5,
    parameter int FAIR        = 0,
    parameter int LOCK_PACKET = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] tail,
    input  logic                 dcts,
    output logic [NUM_PORTS-1:0] grant,
    output logic [NUM_PORTS-1:0] xbar_sel,
    output logic                 rts
);

    localparam int IDX_W = idx_width(NUM_PORTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

    arb_state_t           state;
    logic [NUM_PORTS-1:0] owner;
    logic [IDX_W-1:0]     owner_idx;
    logic [IDX_W-1:0]     next_idx;
    logic [IDX_W-1:0]     pick_start;
    logic [IDX_W-1:0]     pick_idx;
    logic [NUM_PORTS-1:0] pick_onehot;
    logic                 pick_any;
    logic                 xfer;
    logic                 hold;

    assign next_idx   = (owner_idx == LAST_IDX) ? '0 : owner_idx + IDX_W'(1);
    assign pick_start = (state == IDLE || FAIR != 0) ? next_idx : owner_idx;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req    (req),
        .start  (pick_start),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Only dcts reaches the outputs combinationally; req and tail act at the edge.
    assign xfer     = rts && dcts;
    assign hold     = (LOCK_PACKET != 0) && !(|(tail & owner));
    assign grant    = owner & {NUM_PORTS{xfer}};
    assign xbar_sel = (state == ACTIVE) ? owner : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            rts       <= 1'b0;
            owner_idx <= LAST_IDX;
        end else begin
            case (state)
                IDLE: begin
                    rts <= 1'b0;
                    if (pick_any) begin
                        state     <= ACTIVE;
                        owner     <= pick_onehot;
                        owner_idx <= pick_idx;
                    end
                end
                ACTIVE: begin
                    if (xfer) begin
                        // The dropped rts is the mandatory gap cycle after every flit.
                        rts <= 1'b0;
                        if (!hold) begin
                            if (pick_any) begin
                                owner     <= pick_onehot;
                                owner_idx <= pick_idx;
                            end else begin
                                state <= IDLE;
                                owner <= '0;
                            end
                        end
                    end else if (!rts) begin
                        rts <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Bench for noc_rr_arbiter: four configurations driven together, checked
// against an index-based reference model plus directed literal expectations.
module tb_noc_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dcts = 1'b0;
    logic [4:0]  req5 = '0;
    logic [4:0]  tail5 = '0;
    logic [15:0] req16 = '0;
    logic [15:0] tail16 = '0;

    logic [4:0]  grant0, xbar0, grant1, xbar1, grant2, xbar2;
    logic [15:0] grant3, xbar3;
    logic        rts0, rts1, rts2, rts3;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    noc_rr_arbiter #(.NUM_PORTS(5), .FAIR(0), .LOCK_PACKET(0)) d0 (
        .clk(clk), .rst(rst), .req(req5), .tail(tail5), .dcts(dcts),
        .grant(grant0), .xbar_sel(xbar0), .rts(rts0));
    noc_rr_arbiter #(.NUM_PORTS(5), .FAIR(1), .LOCK_PACKET(0)) d1 (
        .clk(clk), .rst(rst), .req(req5), .tail(tail5), .dcts(dcts),
        .grant(grant1), .xbar_sel(xbar1), .rts(rts1));
    noc_rr_arbiter #(.NUM_PORTS(5), .FAIR(0), .LOCK_PACKET(1)) d2 (
        .clk(clk), .rst(rst), .req(req5), .tail(tail5), .dcts(dcts),
        .grant(grant2), .xbar_sel(xbar2), .rts(rts2));
    noc_rr_arbiter #(.NUM_PORTS(16), .FAIR(1), .LOCK_PACKET(0)) d3 (
        .clk(clk), .rst(rst), .req(req16), .tail(tail16), .dcts(dcts),
        .grant(grant3), .xbar_sel(xbar3), .rts(rts3));

    int n_ports[4]  = '{5, 5, 5, 16};
    int fair_cfg[4] = '{0, 1, 0, 1};
    int lock_cfg[4] = '{0, 0, 1, 0};

    bit m_act[4] = '{0, 0, 0, 0};
    int m_own[4] = '{-1, -1, -1, -1};
    bit m_rts[4] = '{0, 0, 0, 0};
    int m_idx[4] = '{4, 4, 4, 15};

    function automatic bit req_bit(int k, int i);
        return (k == 3) ? req16[i] : req5[i];
    endfunction

    function automatic bit tail_bit(int k, int i);
        return (k == 3) ? tail16[i] : tail5[i];
    endfunction

    function automatic int pick(int k, int start);
        int i;
        for (int s = 0; s < n_ports[k]; s++) begin
            i = (start + s) % n_ports[k];
            if (req_bit(k, i)) return i;
        end
        return -1;
    endfunction

    task automatic model_step(int k);
        int p;
        if (rst) begin
            m_act[k] = 1'b0;
            m_own[k] = -1;
            m_rts[k] = 1'b0;
            m_idx[k] = n_ports[k] - 1;
        end else if (!m_act[k]) begin
            p = pick(k, (m_idx[k] + 1) % n_ports[k]);
            if (p >= 0) begin
                m_act[k] = 1'b1;
                m_own[k] = p;
                m_idx[k] = p;
            end
        end else if (m_rts[k] && dcts) begin
            m_rts[k] = 1'b0;
            if (!(lock_cfg[k] != 0 && !tail_bit(k, m_own[k]))) begin
                p = pick(k, (fair_cfg[k] != 0) ? (m_idx[k] + 1) % n_ports[k] : m_idx[k]);
                if (p >= 0) begin
                    m_own[k] = p;
                    m_idx[k] = p;
                end else begin
                    m_act[k] = 1'b0;
                    m_own[k] = -1;
                end
            end
        end else begin
            m_rts[k] = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) model_step(k);
    end

    function automatic logic [15:0] dut_grant(int k);
        case (k)
            0: return {11'b0, grant0};
            1: return {11'b0, grant1};
            2: return {11'b0, grant2};
            default: return grant3;
        endcase
    endfunction

    function automatic logic [15:0] dut_xbar(int k);
        case (k)
            0: return {11'b0, xbar0};
            1: return {11'b0, xbar1};
            2: return {11'b0, xbar2};
            default: return xbar3;
        endcase
    endfunction

    function automatic logic [15:0] dut_rts(int k);
        case (k)
            0: return {15'b0, rts0};
            1: return {15'b0, rts1};
            2: return {15'b0, rts2};
            default: return {15'b0, rts3};
        endcase
    endfunction

    task automatic check_output(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        logic [15:0] sel;
        if (check_en) begin
            for (int k = 0; k < 4; k++) begin
                sel = m_act[k] ? (16'd1 << m_own[k]) : 16'd0;
                check_output($sformatf("model xbar_sel dut%0d", k), dut_xbar(k), sel);
                check_output($sformatf("model grant dut%0d", k), dut_grant(k),
                             (m_rts[k] && dcts) ? sel : 16'd0);
                check_output($sformatf("model rts dut%0d", k), dut_rts(k), {15'b0, m_rts[k]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [4:0] r5, input logic [15:0] r16, input logic d);
        req5  = r5;
        req16 = r16;
        dcts  = d;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        check_en = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            check_output($sformatf("reset rts dut%0d", k), dut_rts(k), 16'h0000);
            check_output($sformatf("reset xbar dut%0d", k), dut_xbar(k), 16'h0000);
        end

        // Held two-port request: fixed vs fair rotation, 16-port wrap-around.
        rst = 1'b0;
        apply_stimulus(5'b00110, 16'h8004, 1'b1);
        tick();
        check_output("first pick xbar d0", {11'b0, xbar0}, 16'h0002);
        check_output("first pick rts d0", {15'b0, rts0}, 16'h0000);
        check_output("wrap pick xbar d3", xbar3, 16'h0004);
        req16 = 16'h8000;
        tick();
        check_output("grant1 d0", {11'b0, grant0}, 16'h0002);
        check_output("grant1 d1", {11'b0, grant1}, 16'h0002);
        check_output("grant1 d3", grant3, 16'h0004);
        tick();
        check_output("gap grant d0", {11'b0, grant0}, 16'h0000);
        check_output("fair xbar d1", {11'b0, xbar1}, 16'h0004);
        check_output("wrap repick xbar d3", xbar3, 16'h8000);
        tick();
        check_output("grant2 d0", {11'b0, grant0}, 16'h0002);
        check_output("grant2 d1", {11'b0, grant1}, 16'h0004);
        check_output("grant2 d3", grant3, 16'h8000);
        tick();
        tick();
        check_output("grant3 d0", {11'b0, grant0}, 16'h0002);
        check_output("grant3 d1", {11'b0, grant1}, 16'h0002);

        // Packet lock: port 0 keeps ownership until its tail flit.
        rst = 1'b1;
        apply_stimulus(5'b00000, 16'h0000, 1'b0);
        tick();
        rst = 1'b0;
        apply_stimulus(5'b01001, 16'h0000, 1'b1);
        tick();
        check_output("lock owner xbar d2", {11'b0, xbar2}, 16'h0001);
        req5 = 5'b01000;
        tick();
        check_output("lock grant1 d2", {11'b0, grant2}, 16'h0001);
        tick();
        tick();
        check_output("lock grant2 d2", {11'b0, grant2}, 16'h0001);
        tick();
        tick();
        tail5 = 5'b00001;
        check_output("lock grant3 d2", {11'b0, grant2}, 16'h0001);
        tick();
        tail5 = 5'b00000;
        check_output("lock handover xbar d2", {11'b0, xbar2}, 16'h0008);
        tick();
        check_output("lock new grant d2", {11'b0, grant2}, 16'h0008);

        // Downstream stall with owner withdrawing its request.
        rst = 1'b1;
        apply_stimulus(5'b00000, 16'h0000, 1'b0);
        tick();
        rst = 1'b0;
        req5 = 5'b00010;
        tick();
        tick();
        for (int c = 0; c < 6; c++) begin
            check_output("stall rts d0", {15'b0, rts0}, 16'h0001);
            check_output("stall xbar d0", {11'b0, xbar0}, 16'h0002);
            check_output("stall grant d0", {11'b0, grant0}, 16'h0000);
            if (c == 1) req5 = 5'b00000;
            tick();
        end
        dcts = 1'b1;
        #1;
        check_output("stall release grant d0", {11'b0, grant0}, 16'h0002);
        tick();
        check_output("stall idle xbar d0", {11'b0, xbar0}, 16'h0000);
        check_output("stall idle rts d0", {15'b0, rts0}, 16'h0000);

        // Reset in the middle of a live handshake.
        apply_stimulus(5'b11111, 16'h0000, 1'b1);
        tick();
        tick();
        check_output("pre-reset grant d0", {11'b0, grant0}, 16'h0004);
        rst = 1'b1;
        tick();
        check_output("mid reset rts d0", {15'b0, rts0}, 16'h0000);
        check_output("mid reset grant d0", {11'b0, grant0}, 16'h0000);
        check_output("mid reset xbar d0", {11'b0, xbar0}, 16'h0000);
        rst = 1'b0;
        tick();
        check_output("post reset pick d0", {11'b0, xbar0}, 16'h0001);
        check_output("post reset pick d1", {11'b0, xbar1}, 16'h0001);
        check_output("post reset pick d2", {11'b0, xbar2}, 16'h0001);

        // Randomized traffic, mixed density, occasional resets.
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 3))
                0: begin
                    req5  = 5'd1 << $urandom_range(0, 4);
                    req16 = 16'd1 << $urandom_range(0, 15);
                end
                1: begin
                    req5  = 5'($urandom) & 5'($urandom);
                    req16 = 16'($urandom) & 16'($urandom);
                end
                2: begin
                    req5  = '0;
                    req16 = '0;
                end
                default: begin
                    req5  = 5'($urandom);
                    req16 = 16'($urandom);
                end
            endcase
            tail5  = 5'($urandom) & 5'($urandom);
            tail16 = 16'($urandom) & 16'($urandom);
            dcts   = ($urandom_range(0, 3) != 0);
            rst    = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        tick();
        check_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
